// File: rtl/ram_arbiter_pkg.sv
// Shared codes for the RAM arbiter: read/write access types, grant
// encoding and a helper that folds the illegal read type onto a full word.
package ram_arbiter_pkg;

    localparam int OPERAND_WIDTH = 64;

    typedef enum logic [2:0] {
        RT_B  = 3'd0,
        RT_H  = 3'd1,
        RT_W  = 3'd2,
        RT_D  = 3'd3,
        RT_BU = 3'd4,
        RT_HU = 3'd5,
        RT_WU = 3'd6
    } read_type_e;

    typedef enum logic [1:0] {
        WT_B = 2'd0,
        WT_H = 2'd1,
        WT_W = 2'd2,
        WT_D = 2'd3
    } write_type_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } grant_e;

    // Code 7 has no meaning to ram_top; a full doubleword read is the safe choice.
    function automatic logic [2:0] legal_rtype(input logic [2:0] rt);
        logic [2:0] res;
        if (rt == 3'd7) begin
            res = RT_D;
        end else begin
            res = rt;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arbiter_rsp.sv
// Single-entry response register with valid/ready handshake; one per requester.
module rsp_slot
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_LEN = OPERAND_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [DATA_LEN-1:0] data_i,
    input  logic                rsp_ready_i,
    output logic                rsp_valid_o,
    output logic [DATA_LEN-1:0] rsp_data_o,
    output logic                free_o
);

    logic                valid_d;
    logic                valid_q;
    logic [DATA_LEN-1:0] data_d;
    logic [DATA_LEN-1:0] data_q;

    // A new load wins over a consume in the same cycle so back-to-back grants stream.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (rsp_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot state; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_LEN{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;
    assign free_o      = !valid_q || rsp_ready_i;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single ram_top: instruction
// fetch (read-only) and load/store share one access per cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int IDX_LEN  = OPERAND_WIDTH,
    parameter int DATA_LEN = OPERAND_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [IDX_LEN-1:0]  if_req_idx,
    output logic                if_rsp_valid,
    input  logic                if_rsp_ready,
    output logic [DATA_LEN-1:0] if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_req_we,
    input  logic [IDX_LEN-1:0]  ls_req_idx,
    input  logic [DATA_LEN-1:0] ls_req_wdata,
    input  logic [2:0]          ls_req_rtype,
    input  logic [1:0]          ls_req_wtype,
    output logic                ls_rsp_valid,
    input  logic                ls_rsp_ready,
    output logic [DATA_LEN-1:0] ls_rsp_data,
    output logic [IDX_LEN-1:0]  ram_idx_o,
    output logic [DATA_LEN-1:0] ram_wdata_o,
    output logic                ram_ren_o,
    output logic                ram_wen_o,
    output logic [2:0]          ram_rtype_o,
    output logic [1:0]          ram_wtype_o,
    input  logic [DATA_LEN-1:0] ram_rdata_i
);

    grant_e              last_grant_d;
    grant_e              last_grant_q;
    logic                if_free_s;
    logic                ls_free_s;
    logic                if_elig_s;
    logic                ls_elig_s;
    logic                gnt_if_s;
    logic                gnt_ls_s;
    logic [DATA_LEN-1:0] ls_load_data_s;

    assign if_elig_s = if_req_valid && if_free_s;
    assign ls_elig_s = ls_req_valid && ls_free_s;

    // Grant selection; nothing is accepted while reset is held.
    always_comb begin
        gnt_if_s = 1'b0;
        gnt_ls_s = 1'b0;
        if (!rst_n) begin
            gnt_if_s = 1'b0;
            gnt_ls_s = 1'b0;
        end else if (if_elig_s && ls_elig_s) begin
            if (last_grant_q == GNT_LS) begin
                gnt_if_s = 1'b1;
            end else begin
                gnt_ls_s = 1'b1;
            end
        end else if (if_elig_s) begin
            gnt_if_s = 1'b1;
        end else if (ls_elig_s) begin
            gnt_ls_s = 1'b1;
        end else begin
            gnt_if_s = 1'b0;
            gnt_ls_s = 1'b0;
        end
    end

    // Round-robin pointer follows every grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_if_s) begin
            last_grant_d = GNT_IF;
        end else if (gnt_ls_s) begin
            last_grant_d = GNT_LS;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Pointer register; reset favours the IFU on the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GNT_LS;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // RAM command; sub-word stores also read so ram_top can merge the old word.
    always_comb begin
        ram_idx_o   = {IDX_LEN{1'b0}};
        ram_wdata_o = {DATA_LEN{1'b0}};
        ram_ren_o   = 1'b0;
        ram_wen_o   = 1'b0;
        ram_rtype_o = 3'd0;
        ram_wtype_o = 2'd0;
        if (gnt_if_s) begin
            ram_idx_o   = if_req_idx;
            ram_ren_o   = 1'b1;
            ram_rtype_o = RT_D;
        end else if (gnt_ls_s) begin
            ram_idx_o = ls_req_idx;
            if (ls_req_we) begin
                ram_wen_o   = 1'b1;
                ram_wdata_o = ls_req_wdata;
                ram_wtype_o = ls_req_wtype;
                ram_ren_o   = (ls_req_wtype != WT_D);
                ram_rtype_o = RT_D;
            end else begin
                ram_ren_o   = 1'b1;
                ram_rtype_o = legal_rtype(ls_req_rtype);
            end
        end else begin
            ram_idx_o = {IDX_LEN{1'b0}};
        end
    end

    // A store acknowledges with zero data.
    always_comb begin
        ls_load_data_s = ram_rdata_i;
        if (ls_req_we) begin
            ls_load_data_s = {DATA_LEN{1'b0}};
        end else begin
            ls_load_data_s = ram_rdata_i;
        end
    end

    rsp_slot #(.DATA_LEN(DATA_LEN)) u_if_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gnt_if_s),
        .data_i     (ram_rdata_i),
        .rsp_ready_i(if_rsp_ready),
        .rsp_valid_o(if_rsp_valid),
        .rsp_data_o (if_rsp_data),
        .free_o     (if_free_s)
    );

    rsp_slot #(.DATA_LEN(DATA_LEN)) u_ls_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gnt_ls_s),
        .data_i     (ls_load_data_s),
        .rsp_ready_i(ls_rsp_ready),
        .rsp_valid_o(ls_rsp_valid),
        .rsp_data_o (ls_rsp_data),
        .free_o     (ls_free_s)
    );

    assign if_req_ready = gnt_if_s;
    assign ls_req_ready = gnt_ls_s;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one `ram_top` instance between two requesters: instruction fetch (IFU, read-only, full 64-bit) and load/store unit (LSU, read or write, any width).
- Valid/ready request channel and valid/ready response channel per requester.
- One RAM access per cycle. Round-robin on conflict. Registered response.
- Sits between the IF/MEM stages and `ram_top`. Drives `ren`/`wen`/`read_type`/`write_type`/`idx`.

Parameters:
- IDX_LEN, `OPERAND_WIDTH (64): RAM index width.
- DATA_LEN, `OPERAND_WIDTH (64): data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req_valid  in  1  IFU request.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_req_idx  in  IDX_LEN  IFU index.
- if_rsp_valid  out  1  IFU read data valid.
- if_rsp_ready  in  1  IFU consumes response.
- if_rsp_data  out  DATA_LEN  IFU read data.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted.
- ls_req_we  in  1  1 = write, 0 = read.
- ls_req_idx  in  IDX_LEN  LSU index.
- ls_req_wdata  in  DATA_LEN  store data.
- ls_req_rtype  in  3  read_type code, 0..6.
- ls_req_wtype  in  2  write_type code, 0..3.
- ls_rsp_valid  out  1  load data / store ack valid.
- ls_rsp_ready  in  1  LSU consumes response.
- ls_rsp_data  out  DATA_LEN  load data; 0 for store ack.
- ram_idx_o  out  IDX_LEN  to `ram_top` idx_i.
- ram_wdata_o  out  DATA_LEN  to `ram_top` w_data_i.
- ram_ren_o  out  1  to `ram_top` ren.
- ram_wen_o  out  1  to `ram_top` wen.
- ram_rtype_o  out  3  to `ram_top` read_type.
- ram_wtype_o  out  2  to `ram_top` write_type.
- ram_rdata_i  in  DATA_LEN  from `ram_top` r_data_o; combinational in the grant cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All rsp_valid = 0, rsp_data = 0.
  - `last_grant` = LSU, so the IFU wins the first conflict.
  - All ram_* outputs = 0.
  - Any request presented during reset is not accepted (req_ready = 0).
  - An in-flight response is dropped.
- Eligibility: requester X is eligible when req_valid=1 and its response slot is free: `!X_rsp_valid || X_rsp_ready`.
- Grant, combinational in the cycle:
  - Only one eligible → grant it.
  - Both eligible → grant the one not equal to `last_grant`.
  - `X_req_ready` = grant to X. At most one ready is high.
  - `last_grant` updates on every grant.
- RAM drive during a grant cycle; all ram_* outputs are 0 otherwise:
  - IFU grant: ren=1, wen=0, rtype=3.
  - LSU read: ren=1, wen=0, rtype=ls_req_rtype.
  - LSU write: wen=1, wtype=ls_req_wtype, wdata=ls_req_wdata. ren=1 when wtype<3, because the sub-word merge needs the old word; ren=0 when wtype=3. rtype=3.
  - idx passes through from the granted requester.
- Response:
  - At the clk edge ending the grant cycle, the granted requester's rsp_valid is set.
  - rsp_data = ram_rdata_i for reads, 0 for writes.
  - Latency from accepted request to rsp_valid: exactly 1 cycle.
  - rsp_valid holds and data is stable until rsp_ready.
  - rsp_valid clears on rsp_ready unless a new grant to the same requester happens that cycle. Back-to-back grants therefore give one access per cycle.
- Write commit: the RAM write takes effect at the end of the grant cycle. An LSU read of the same idx granted the next cycle sees the new data.
- Backpressure: a requester with rsp_valid=1 and rsp_ready=0 is ineligible. The other requester may take every cycle.
- Starvation: with both continuously eligible, grants alternate IF, LS, IF, LS, ...
- Illegal ls_req_rtype=7: treated as 3.

Decomposition:
- Shared defines header holds:
  - read-type codes (RT_B=0, RT_H=1, RT_W=2, RT_D=3, RT_BU=4, RT_HU=5, RT_WU=6);
  - write-type codes (WT_B=0, WT_H=1, WT_W=2, WT_D=3);
  - grant encoding (GNT_IF=0, GNT_LS=1).
- One sub-module: `rsp_slot`, a single-entry response register with valid/ready. Instantiated once per requester.

Test Plan:
- Reset, then IFU only: idx=4 with RAM[4]=0x1122334455667788 → if_req_ready=1 same cycle; next cycle if_rsp_valid=1, data 0x1122334455667788.
- Conflict from reset, IFU idx=1 and LSU read idx=2 both valid every cycle, responses always ready → grants IF, LS, IF, LS. Each rsp_valid appears 1 cycle after its grant.
- LSU byte store: wtype=0, wdata=0xAB, idx=3, RAM[3]=0xFFFF_FFFF_FFFF_FF00 → ram_ren_o=1, ram_wen_o=1 in the grant cycle. Next-cycle read with rtype=3 returns 0xFFFF_FFFF_FFFF_FFAB; ls_rsp_data=0 for the store ack.
- Signed byte load: rtype=0, RAM[5] low byte 0x80 → ls_rsp_data=0xFFFF_FFFF_FFFF_FF80. With rtype=4 → 0x80.
- Backpressure: if_rsp_ready=0 held 3 cycles with both requesting → IFU gets no grant; LSU granted each cycle; if_rsp_data stable. Raising if_rsp_ready regrants IFU in the same cycle.
- rst_n=0 asserted while if_rsp_valid=1 → next edge: all rsp_valid=0, ram_* outputs=0. First conflict after release goes to IFU.
